// File: rtl/modn_pkg.sv
// Shared constants and the count-step helper for the programmable modulo-N counter.
package modn_pkg;

   // Smallest modulus accepted by a write; anything below is rejected with err.
   localparam int MOD_MIN = 2;

   // Values of the up input.
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Wrapping next count for count q, modulus m and direction up.
   // Operands are carried at 32 bits so one helper serves any WIDTH up to 32.
   // The caller casts the result back to its own width.
   function automatic logic [31:0] modn_next(input logic [31:0] q,
                                             input logic [31:0] m,
                                             input logic        up);
      logic [31:0] nxt;
      if (up == DIR_UP) begin
         nxt = (q == m - 32'd1) ? 32'd0 : q + 32'd1;
      end else begin
         nxt = (q == 32'd0) ? m - 32'd1 : q - 32'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/modn_counter_prog_if.sv
// Control and status bundle of the programmable modulo-N counter.
interface modn_counter_prog_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             up;
   logic             oneshot;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             mod_we;
   logic [WIDTH-1:0] mod_in;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] mod_q;
   logic             tc;
   logic             wrap;
   logic             done;
   logic             err;

   // Side that drives the controls and watches the count.
   modport master (
      output en, up, oneshot, load, load_val, mod_we, mod_in,
      input  q, mod_q, tc, wrap, done, err
   );

   // The counter itself.
   modport slave (
      input  en, up, oneshot, load, load_val, mod_we, mod_in,
      output q, mod_q, tc, wrap, done, err
   );
endinterface

// File: rtl/modn_mod_reg.sv
// Modulus register: validates writes, holds the active modulus M and pulses err
// for one cycle on every rejected write.
module modn_mod_reg
   import modn_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int MOD_DEFAULT = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mod_we,
   input  logic [WIDTH-1:0] mod_in,
   output logic [WIDTH-1:0] mod_q,
   output logic             accept,
   output logic             err
);

   logic [WIDTH-1:0] mod_reg;
   logic             err_reg;
   logic             reject;

   // A write is taken only when the new modulus is at least MOD_MIN.
   always_comb begin
      accept = mod_we && (mod_in >= WIDTH'(MOD_MIN));
      reject = mod_we && (mod_in <  WIDTH'(MOD_MIN));
   end

   // Modulus and error-pulse registers; err is re-evaluated every edge so
   // consecutive rejected writes give consecutive pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mod_reg <= WIDTH'(MOD_DEFAULT);
         err_reg <= 1'b0;
      end else begin
         if (accept) begin
            mod_reg <= mod_in;
         end
         err_reg <= reject;
      end
   end

   assign mod_q = mod_reg;
   assign err   = err_reg;

endmodule

// File: rtl/modn_counter_prog.sv
// Runtime-programmable modulo-N up/down counter with load, one-shot mode,
// terminal-count flag and a registered wrap pulse for cascading.
module modn_counter_prog
   import modn_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int MOD_DEFAULT = 6
) (
   input logic                clk,
   input logic                rst,
   modn_counter_prog_if.slave bus
);

   logic [WIDTH-1:0] q_reg, q_next;
   logic             wrap_reg, wrap_next;
   logic             done_reg, done_next;
   logic [WIDTH-1:0] mod_q;
   logic             mod_accept;
   logic             mod_err;
   logic [WIDTH-1:0] mod_eff;
   logic [WIDTH-1:0] term_val;
   logic             at_term;
   logic [WIDTH-1:0] q_step;

   modn_mod_reg #(
      .WIDTH       (WIDTH),
      .MOD_DEFAULT (MOD_DEFAULT)
   ) u_mod_reg (
      .clk    (clk),
      .rst    (rst),
      .mod_we (bus.mod_we),
      .mod_in (bus.mod_in),
      .mod_q  (mod_q),
      .accept (mod_accept),
      .err    (mod_err)
   );

   // Terminal value for the current direction, the wrapping step, and the
   // modulus a same-edge load must clamp against.
   always_comb begin
      term_val = (bus.up == DIR_UP) ? mod_q - WIDTH'(1) : '0;
      at_term  = (q_reg == term_val);
      q_step   = WIDTH'(modn_next(32'(q_reg), 32'(mod_q), bus.up));
      mod_eff  = mod_accept ? bus.mod_in : mod_q;
   end

   // Next count and flags: load beats a modulus write, which beats a step.
   always_comb begin
      q_next    = q_reg;
      done_next = done_reg;
      wrap_next = 1'b0;
      if (bus.load) begin
         q_next    = (bus.load_val > mod_eff - WIDTH'(1)) ? mod_eff - WIDTH'(1)
                                                          : bus.load_val;
         done_next = 1'b0;
      end else if (mod_accept) begin
         // Shrinking below the current count restarts at 0; no step this edge.
         if (q_reg >= bus.mod_in) begin
            q_next = '0;
         end
      end else if (bus.en && !done_reg) begin
         if (at_term && bus.oneshot) begin
            done_next = 1'b1;
         end else begin
            q_next    = q_step;
            wrap_next = at_term;
         end
      end
   end

   // Count, wrap and done registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg    <= '0;
         wrap_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         q_reg    <= q_next;
         wrap_reg <= wrap_next;
         done_reg <= done_next;
      end
   end

   assign bus.q     = q_reg;
   assign bus.mod_q = mod_q;
   assign bus.tc    = at_term;
   assign bus.wrap  = wrap_reg;
   assign bus.done  = done_reg;
   assign bus.err   = mod_err;

endmodule

// File: doc/modn_counter_prog.md
# modn_counter_prog

Runtime-programmable modulo-N counter that replaces the fixed-modulus counter in timing and sequencing paths. It adds a write-programmable modulus, up/down counting, synchronous load, count enable, a one-shot mode, a terminal-count flag and a registered wrap pulse for cascading. It sits beside clock-enable generators and FSM sequencers as a single-clock peripheral.

## Interface
- `WIDTH`, 8: counter and modulus width in bits.
- `MOD_DEFAULT`, 6: modulus after reset. Legal range is 2..2^WIDTH-1.

Ports:
- `clk` in 1: clock, rising edge. One clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: count enable.
- `up` in 1: direction. 1 counts up, 0 counts down.
- `oneshot` in 1: 1 stops at the terminal value, 0 wraps.
- `load` in 1: synchronous load of `load_val`.
- `load_val` in WIDTH: value to load.
- `mod_we` in 1: modulus write strobe.
- `mod_in` in WIDTH: new modulus.
- `q` out WIDTH: count, registered.
- `mod_q` out WIDTH: active modulus M, registered.
- `tc` out 1: terminal-count flag, combinational.
- `wrap` out 1: one-cycle wrap pulse, registered.
- `done` out 1: sticky one-shot completion flag, registered.
- `err` out 1: one-cycle pulse on a rejected modulus write, registered.

## Operation
- Count range is 0..M-1. All compares and arithmetic are unsigned. `q` never leaves this range, so it cannot overflow.
- Terminal value T is M-1 when `up`=1 and 0 when `up`=0. `tc` = (`q`==T).
- Modulus write:
  - `mod_we` with `mod_in` >= 2 is accepted: `mod_q` takes `mod_in` at the next edge.
  - `mod_we` with `mod_in` < 2 is rejected: `mod_q` is unchanged and `err` pulses for one cycle.
- Per-edge priority, highest first:
  1. `load`: `q` takes min(`load_val`, M'-1) and `done` clears. M' is the new modulus if a write is accepted on the same edge, otherwise the current M. No step occurs.
  2. Accepted `mod_we`: `q` clears to 0 if `q` >= new M, otherwise holds. No count step occurs on this edge.
  3. `en`=1 and `done`=0: one count step, defined below.
  4. Otherwise `q` holds.
- Count step:
  - Up: if `q`<M-1 then `q`+1. If `q`==M-1, go to 0 and pulse `wrap`.
  - Down: if `q`>0 then `q`-1. If `q`==0, go to M-1 and pulse `wrap`.
  - One-shot: a step taken with `q`==T holds `q`, sets `done` and does not pulse `wrap`. While `done`=1, counting is frozen.
- `done` clears only on `load` or `rst`.
- Toggling `up` or `oneshot` mid-count takes effect on the next step. No state is flushed.

## Timing
- Reset values, applied asynchronously: `q`=0, `mod_q`=`MOD_DEFAULT`, `wrap`=0, `done`=0, `err`=0.
- After reset release, the first step happens on the first rising edge with `en`=1.
- All registered outputs update on the edge that samples the controlling inputs, so the latency is one edge.
- `tc` follows `q`, `mod_q` and `up` in the same cycle. There is no register on it.
- `wrap` and `err` are high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
  - Example: with M=2 and `en` held high, `wrap` is high every second cycle.
- Cascading: feeding `wrap` into the `en` of the next stage gives a one-cycle ripple delay per stage.
- `rst` asserted mid-count or mid-write forces the reset values immediately. Any write in flight is discarded.

## Structure
- Shared package `modn_pkg`:
  - `MOD_MIN` = 2.
  - Direction constants `DIR_UP` and `DIR_DOWN`.
  - A function `modn_next` that returns the next count from (`q`, M, `up`).
- Sub-module `modn_mod_reg` holds the modulus register, the write validation and the `err` pulse, and exports M.
- The top level holds the count, load, one-shot and `wrap` logic.

## Test plan
- Reset, then `en`=1 and `up`=1 for 13 cycles with M=6:
  - `q` runs 0,1,2,3,4,5,0,1,…
  - `wrap` pulses on the edges where 5 goes to 0.
  - `tc`=1 while `q`=5.
- `up`=0 with M=6 from reset:
  - `q` runs 5,4,3,2,1,0,5.
  - `wrap` pulses on the 0 to 5 edge.
  - `tc`=1 while `q`=0.
- Modulus writes:
  - At `q`=4, write `mod_in`=3: next `q`=0 and `mod_q`=3. Counting then runs 1,2,0.
  - Write `mod_in`=1: `err` pulses for one cycle and `mod_q` stays 3.
- `load`=1 and `load_val`=200 with M=6: `q`=5.
  - `load` and `mod_we`(10) on the same edge with `load_val`=7: `q`=7 and `mod_q`=10.
- One-shot:
  - With `oneshot`=1, `up`=1, M=4 and `en` high: `q` runs 0,1,2,3,3; `done` sets on the edge after `q` reaches 3; `wrap` never pulses.
  - A later `load` with `load_val`=0 clears `done` and counting resumes.
- Assert `rst` asynchronously mid-cycle at `q`=3 with M=9 written earlier:
  - `q`=0, `mod_q`=6 and all flags are 0 before the next edge.
